// File: rtl/conv_window_scheduler_if.sv
// Handshake/bus bundle between conv_window_scheduler (master) and its buffers/MAC (slave).
// CONV_SCHED_STALL_CNT_EN adds the 16-bit stall_cnt signal.
interface conv_window_scheduler_if #(
   parameter int unsigned IA_W = 5,
   parameter int unsigned FA_W = 4,
   parameter int unsigned OA_W = 4
);
   logic            start;
   logic            busy;
   logic            done;
   logic            ifmap_rd_en;
   logic [IA_W-1:0] ifmap_rd_addr;
   logic [FA_W-1:0] filter_rd_addr;
   logic            mac_valid;
   logic            mac_clear;
   logic            mac_last;
   logic            ofmap_wr_en;
   logic [OA_W-1:0] ofmap_wr_addr;
   logic            ofmap_ready;
`ifdef CONV_SCHED_STALL_CNT_EN
   logic [15:0]     stall_cnt;
`endif

   modport master (
`ifdef CONV_SCHED_STALL_CNT_EN
      output stall_cnt,
`endif
      input  start, ofmap_ready,
      output busy, done, ifmap_rd_en, ifmap_rd_addr, filter_rd_addr,
             mac_valid, mac_clear, mac_last, ofmap_wr_en, ofmap_wr_addr
   );

   modport slave (
`ifdef CONV_SCHED_STALL_CNT_EN
      input  stall_cnt,
`endif
      output start, ofmap_ready,
      input  busy, done, ifmap_rd_en, ifmap_rd_addr, filter_rd_addr,
             mac_valid, mac_clear, mac_last, ofmap_wr_en, ofmap_wr_addr
   );
endinterface

// File: rtl/conv_window_scheduler.sv
// Convolution window sequencer: walks the ifmap window by window, issuing buffer reads, MAC strobes and ofmap writes.
// Optional feature macro CONV_SCHED_STALL_CNT_EN adds a saturating ofmap back-pressure counter (stall_cnt).
module conv_window_scheduler #(
   parameter int unsigned IFMAP_SIZE  = 5,
   parameter int unsigned FILTER_SIZE = 3,
   parameter int unsigned STRIDE      = 1,
   parameter int unsigned OFMAP_SIZE  = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1,
   parameter int unsigned IA_W = (IFMAP_SIZE * IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE * IFMAP_SIZE) : 1,
   parameter int unsigned FA_W = (FILTER_SIZE * FILTER_SIZE > 1) ? $clog2(FILTER_SIZE * FILTER_SIZE) : 1,
   parameter int unsigned OA_W = (OFMAP_SIZE * OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE * OFMAP_SIZE) : 1
) (
   input  logic clk,
   input  logic rst,
   conv_window_scheduler_if.master bus
);
   localparam int unsigned FC_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam int unsigned OC_W = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;
   localparam logic [FC_W-1:0] F_LAST = FC_W'(FILTER_SIZE - 1);
   localparam logic [OC_W-1:0] O_LAST = OC_W'(OFMAP_SIZE - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, DONE} state_e;

   state_e          state_q, state_d;
   logic [OC_W-1:0] ox_q, ox_d, oy_q, oy_d;
   logic [FC_W-1:0] fx_q, fx_d, fy_q, fy_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic            rd_en_q, rd_en_d, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
   logic            mac_valid_q, mac_valid_d, mac_clear_q, mac_clear_d, mac_last_q, mac_last_d;
   logic            wr_en_q, wr_en_d;
   logic [IA_W-1:0] ia_q, ia_d;
   logic [FA_W-1:0] fa_q, fa_d;
   logic [OA_W-1:0] oa_q, oa_d;

   always_comb begin
      state_d = state_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               ox_d    = '0;
               oy_d    = '0;
               fx_d    = '0;
               fy_d    = '0;
            end
         end
         LOAD: begin
            if (fx_q == F_LAST) begin
               fx_d = '0;
               if (fy_q == F_LAST) begin
                  fy_d    = '0;
                  state_d = WAIT;
               end else begin
                  fy_d = fy_q + FC_W'(1);
               end
            end else begin
               fx_d = fx_q + FC_W'(1);
            end
         end
         WAIT: state_d = WRITE;
         WRITE: begin
            if (bus.ofmap_ready) begin
               state_d = LOAD;
               if (ox_q == O_LAST) begin
                  ox_d = '0;
                  if (oy_q == O_LAST) begin
                     oy_d    = '0;
                     state_d = DONE;
                  end else begin
                     oy_d = oy_q + OC_W'(1);
                  end
               end else begin
                  ox_d = ox_q + OC_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so strobes line up with the cycle the state is entered.
      rd_en_d     = (state_d == LOAD);
      rd_first_d  = rd_en_d && (fx_d == '0) && (fy_d == '0);
      rd_last_d   = rd_en_d && (fx_d == F_LAST) && (fy_d == F_LAST);
      mac_valid_d = rd_en_q;
      mac_clear_d = rd_first_q;
      mac_last_d  = rd_last_q;
      wr_en_d     = (state_d == WRITE);
      busy_d      = (state_d == LOAD) || (state_d == WAIT) || (state_d == WRITE);
      done_d      = (state_d == DONE);

      ia_d = ia_q;
      fa_d = fa_q;
      oa_d = oa_q;
      if (rd_en_d) begin
         ia_d = IA_W'((32'(oy_d) * STRIDE + 32'(fy_d)) * IFMAP_SIZE + 32'(ox_d) * STRIDE + 32'(fx_d));
         fa_d = FA_W'(32'(fy_d) * FILTER_SIZE + 32'(fx_d));
      end
      if (wr_en_d) begin
         oa_d = OA_W'(32'(oy_d) * OFMAP_SIZE + 32'(ox_d));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ox_q        <= '0;
         oy_q        <= '0;
         fx_q        <= '0;
         fy_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_first_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_clear_q <= 1'b0;
         mac_last_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         ia_q        <= '0;
         fa_q        <= '0;
         oa_q        <= '0;
      end else begin
         state_q     <= state_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         fx_q        <= fx_d;
         fy_q        <= fy_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         rd_first_q  <= rd_first_d;
         rd_last_q   <= rd_last_d;
         mac_valid_q <= mac_valid_d;
         mac_clear_q <= mac_clear_d;
         mac_last_q  <= mac_last_d;
         wr_en_q     <= wr_en_d;
         ia_q        <= ia_d;
         fa_q        <= fa_d;
         oa_q        <= oa_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.ifmap_rd_en    = rd_en_q;
   assign bus.ifmap_rd_addr  = ia_q;
   assign bus.filter_rd_addr = fa_q;
   assign bus.mac_valid      = mac_valid_q;
   assign bus.mac_clear      = mac_clear_q;
   assign bus.mac_last       = mac_last_q;
   assign bus.ofmap_wr_en    = wr_en_q;
   assign bus.ofmap_wr_addr  = oa_q;

`ifdef CONV_SCHED_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IDLE) && bus.start) begin
         stall_cnt_d = '0;
      end else if ((state_q == WRITE) && !bus.ofmap_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: default 5/3/1 instance plus a 4/2/2 instance.
module tb_conv_window_scheduler;
   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_window_scheduler_if #(.IA_W(5), .FA_W(4), .OA_W(4)) bus_a ();
   conv_window_scheduler_if #(.IA_W(4), .FA_W(2), .OA_W(2)) bus_b ();

   conv_window_scheduler dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   conv_window_scheduler #(.IFMAP_SIZE(4), .FILTER_SIZE(2), .STRIDE(2)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b));

   int unsigned exp_ia_a[$], exp_fa_a[$], exp_mac_a[$], exp_wr_a[$], exp_done_a[$];
   int unsigned exp_ia_b[$], exp_fa_b[$], exp_mac_b[$], exp_wr_b[$], exp_done_b[$];
   int unsigned rd_log_a[$], rd_log_b[$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int unsigned c);
      while (cyc < c) tick();
   endtask

   // Expected reads/MAC flags/writes of one full run, straight from the address formulas.
   task automatic push_run_a(input int unsigned t0, input int unsigned stalls);
      for (int unsigned oy = 0; oy < 3; oy++)
         for (int unsigned ox = 0; ox < 3; ox++) begin
            for (int unsigned fy = 0; fy < 3; fy++)
               for (int unsigned fx = 0; fx < 3; fx++) begin
                  exp_ia_a.push_back((oy + fy) * 5 + ox + fx);
                  exp_fa_a.push_back(fy * 3 + fx);
                  exp_mac_a.push_back(((fx == 0 && fy == 0) ? 2 : 0) + ((fx == 2 && fy == 2) ? 1 : 0));
               end
            exp_wr_a.push_back(oy * 3 + ox);
         end
      exp_done_a.push_back(t0 + 100 + stalls);
   endtask

   task automatic push_run_b(input int unsigned t0);
      for (int unsigned oy = 0; oy < 2; oy++)
         for (int unsigned ox = 0; ox < 2; ox++) begin
            for (int unsigned fy = 0; fy < 2; fy++)
               for (int unsigned fx = 0; fx < 2; fx++) begin
                  exp_ia_b.push_back((oy * 2 + fy) * 4 + ox * 2 + fx);
                  exp_fa_b.push_back(fy * 2 + fx);
                  exp_mac_b.push_back(((fx == 0 && fy == 0) ? 2 : 0) + ((fx == 1 && fy == 1) ? 1 : 0));
               end
            exp_wr_b.push_back(oy * 2 + ox);
         end
      exp_done_b.push_back(t0 + 25);
   endtask

   function automatic int unsigned outs_a();
      return 32'({bus_a.busy, bus_a.done, bus_a.ifmap_rd_en, bus_a.mac_valid, bus_a.mac_clear,
                  bus_a.mac_last, bus_a.ofmap_wr_en, bus_a.ifmap_rd_addr, bus_a.filter_rd_addr,
                  bus_a.ofmap_wr_addr});
   endfunction

   always @(negedge clk) begin
      if (bus_a.ifmap_rd_en) begin
         rd_log_a.push_back(32'(bus_a.ifmap_rd_addr));
         if (exp_ia_a.size() == 0) check("a_rd_unexpected", 32'(bus_a.ifmap_rd_en), 0);
         else begin
            check("a_ifmap_addr", 32'(bus_a.ifmap_rd_addr), exp_ia_a.pop_front());
            check("a_filter_addr", 32'(bus_a.filter_rd_addr), exp_fa_a.pop_front());
         end
      end
      if (bus_a.mac_valid) begin
         if (exp_mac_a.size() == 0) check("a_mac_unexpected", 32'(bus_a.mac_valid), 0);
         else check("a_mac_clear_last", 32'({bus_a.mac_clear, bus_a.mac_last}), exp_mac_a.pop_front());
      end else if (bus_a.mac_clear || bus_a.mac_last) begin
         check("a_mac_flags_idle", 32'({bus_a.mac_clear, bus_a.mac_last}), 0);
      end
      if (bus_a.ofmap_wr_en) begin
         if (exp_wr_a.size() == 0) check("a_wr_unexpected", 32'(bus_a.ofmap_wr_en), 0);
         else begin
            check("a_wr_addr", 32'(bus_a.ofmap_wr_addr), exp_wr_a[0]);
            if (bus_a.ofmap_ready) void'(exp_wr_a.pop_front());
         end
      end
      if (bus_a.done) begin
         if (exp_done_a.size() == 0) check("a_done_unexpected", 32'(bus_a.done), 0);
         else check("a_done_cycle", cyc, exp_done_a.pop_front());
         check("a_busy_at_done", 32'(bus_a.busy), 0);
      end
   end

   always @(negedge clk) begin
      if (bus_b.ifmap_rd_en) begin
         rd_log_b.push_back(32'(bus_b.ifmap_rd_addr));
         if (exp_ia_b.size() == 0) check("b_rd_unexpected", 32'(bus_b.ifmap_rd_en), 0);
         else begin
            check("b_ifmap_addr", 32'(bus_b.ifmap_rd_addr), exp_ia_b.pop_front());
            check("b_filter_addr", 32'(bus_b.filter_rd_addr), exp_fa_b.pop_front());
         end
      end
      if (bus_b.mac_valid) begin
         if (exp_mac_b.size() == 0) check("b_mac_unexpected", 32'(bus_b.mac_valid), 0);
         else check("b_mac_clear_last", 32'({bus_b.mac_clear, bus_b.mac_last}), exp_mac_b.pop_front());
      end
      if (bus_b.ofmap_wr_en) begin
         if (exp_wr_b.size() == 0) check("b_wr_unexpected", 32'(bus_b.ofmap_wr_en), 0);
         else begin
            check("b_wr_addr", 32'(bus_b.ofmap_wr_addr), exp_wr_b[0]);
            if (bus_b.ofmap_ready) void'(exp_wr_b.pop_front());
         end
      end
      if (bus_b.done) begin
         if (exp_done_b.size() == 0) check("b_done_unexpected", 32'(bus_b.done), 0);
         else check("b_done_cycle", cyc, exp_done_b.pop_front());
      end
   end

   task automatic check_drained_a(input string tag);
      check({tag, "_rd_left"}, exp_ia_a.size(), 0);
      check({tag, "_mac_left"}, exp_mac_a.size(), 0);
      check({tag, "_wr_left"}, exp_wr_a.size(), 0);
      check({tag, "_done_left"}, exp_done_a.size(), 0);
   endtask

   initial begin : stim
      int unsigned t0;
      int unsigned win0_a[9]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      int unsigned win21_a[9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
      int unsigned win3_b[4]  = '{10, 11, 14, 15};

      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.start = 1'b0; bus_a.ofmap_ready = 1'b1;
      bus_b.start = 1'b0; bus_b.ofmap_ready = 1'b1;
      repeat (3) tick();
      check("a_reset_outputs", outs_a(), 0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      // Run 1: both instances, ready tied high.
      t0 = cyc;
      rd_log_a.delete(); rd_log_b.delete();
      push_run_a(t0, 0); push_run_b(t0);
      bus_a.start = 1'b1; bus_b.start = 1'b1;
      check("a_busy_c0", 32'(bus_a.busy), 0);
      tick();
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      check("a_busy_c1", 32'(bus_a.busy), 1);
      check("a_rd_en_c1", 32'(bus_a.ifmap_rd_en), 1);
      check("a_mac_valid_c1", 32'(bus_a.mac_valid), 0);
      tick();
      check("a_mac_clear_c2", 32'({bus_a.mac_valid, bus_a.mac_clear}), 3);
      go_to(t0 + 100);
      check("a_done_c100", 32'({bus_a.done, bus_a.busy}), 2);
      tick();
      check("a_done_c101", 32'(bus_a.done), 0);
      check("a_rd_count", rd_log_a.size(), 81);
      check("b_rd_count", rd_log_b.size(), 16);
      for (int i = 0; i < 9; i++) begin
         if (rd_log_a.size() == 81) begin
            check("a_win0_addr", rd_log_a[i], win0_a[i]);
            check("a_win21_addr", rd_log_a[45 + i], win21_a[i]);
         end
      end
      for (int i = 0; i < 4; i++)
         if (rd_log_b.size() == 16) check("b_win3_addr", rd_log_b[12 + i], win3_b[i]);
      check_drained_a("run1");
      check("b_done_left", exp_done_b.size(), 0);
      check("b_wr_left", exp_wr_b.size(), 0);
      tick();

      // Run 2: 5 cycles of back-pressure while pixel 4 is being written.
      t0 = cyc;
      push_run_a(t0, 5);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      go_to(t0 + 55);
      bus_a.ofmap_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("a_stall_wr_en", 32'(bus_a.ofmap_wr_en), 1);
         check("a_stall_wr_addr", 32'(bus_a.ofmap_wr_addr), 4);
         tick();
      end
      bus_a.ofmap_ready = 1'b1;
      go_to(t0 + 106);
`ifdef CONV_SCHED_STALL_CNT_EN
      check("a_stall_cnt", 32'(bus_a.stall_cnt), 5);
`endif
      check_drained_a("run2");

      // Run 3: start re-pulsed while busy and in DONE must be ignored.
      t0 = cyc;
      push_run_a(t0, 0);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      go_to(t0 + 3);  bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
      go_to(t0 + 50); bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
      go_to(t0 + 100);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      go_to(t0 + 103);
      check("a_no_rerun_busy", 32'({bus_a.busy, bus_a.ifmap_rd_en}), 0);
`ifdef CONV_SCHED_STALL_CNT_EN
      check("a_stall_cnt_cleared", 32'(bus_a.stall_cnt), 0);
`endif
      check_drained_a("run3");

      // Run 4: start held high relaunches in the cycle after DONE.
      t0 = cyc;
      push_run_a(t0, 0);
      push_run_a(t0 + 101, 0);
      bus_a.start = 1'b1;
      go_to(t0 + 101);
      check("a_idle_after_done", 32'({bus_a.busy, bus_a.done}), 0);
      tick();
      bus_a.start = 1'b0;
      check("a_relaunch_rd_en", 32'({bus_a.busy, bus_a.ifmap_rd_en}), 3);
      go_to(t0 + 203);
      check_drained_a("run4");

      // Run 5: reset mid-run, then a clean run.
      t0 = cyc;
      push_run_a(t0, 0);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      go_to(t0 + 40);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      check("a_outputs_after_rst", outs_a(), 0);
      exp_ia_a.delete(); exp_fa_a.delete(); exp_mac_a.delete();
      exp_wr_a.delete(); exp_done_a.delete();
      go_to(t0 + 110);
      check("a_idle_after_rst", 32'(bus_a.busy), 0);
      t0 = cyc;
      push_run_a(t0, 0);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      go_to(t0 + 102);
      check_drained_a("run5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequencer for the convolution stage of the CNN datapath. Walks an IFMAP_SIZE×IFMAP_SIZE input feature map with a FILTER_SIZE×FILTER_SIZE window at STRIDE, issuing ifmap/filter buffer read addresses and MAC control strobes. It also writes each finished output pixel to the ofmap buffer under a ready handshake. Sits between the ifmap/filter SRAMs, the MAC accumulator, and the ofmap buffer that feeds max pooling.

## Interface
- IFMAP_SIZE, 5, input feature map side length
- FILTER_SIZE, 3, kernel side length
- STRIDE, 1, window step in both dimensions
- OFMAP_SIZE, (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1, derived output side length; must be ≥1
- IA_W / FA_W / OA_W, $clog2 of IFMAP_SIZE², FILTER_SIZE², OFMAP_SIZE² (min 1), address widths

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one full-map convolution; sampled only in IDLE
- busy  out  1  high from cycle after start acceptance until done cycle (exclusive)
- done  out  1  one-cycle pulse after final ofmap write
- ifmap_rd_en  out  1  ifmap and filter read strobe
- ifmap_rd_addr  out  IA_W  (oy*STRIDE+fy)*IFMAP_SIZE + ox*STRIDE+fx
- filter_rd_addr  out  FA_W  fy*FILTER_SIZE+fx
- mac_valid  out  1  read data valid at MAC (rd_en delayed 1 cycle; buffers have 1-cycle read latency)
- mac_clear  out  1  with first mac_valid of a window; MAC loads product instead of accumulating
- mac_last  out  1  with final mac_valid of a window
- ofmap_wr_en  out  1  result write request
- ofmap_wr_addr  out  OA_W  oy*OFMAP_SIZE+ox
- ofmap_ready  in  1  ofmap buffer accepts write when high with ofmap_wr_en

## Operation
- FSM states: IDLE, LOAD, WAIT, WRITE, DONE.
- IDLE: all strobes low. start=1 → clear ox, oy, fx, fy → LOAD.
- LOAD: ifmap_rd_en=1 each cycle. fx increments; wraps to 0 at FILTER_SIZE-1 with fy increment. At fx=fy=FILTER_SIZE-1 → WAIT.
- WAIT: one cycle. Last tap's mac_valid/mac_last present. → WRITE.
- WRITE: ofmap_wr_en=1, ofmap_wr_addr stable. On ofmap_ready=1, advance ox, wrapping at OFMAP_SIZE-1 with oy increment. If last pixel (ox=oy=OFMAP_SIZE-1) → DONE, else → LOAD with fx=fy=0. On ofmap_ready=0, hold indefinitely with all outputs stable.
- DONE: done=1, busy=0 for one cycle → IDLE.
- Address arithmetic is unsigned, computed in full width and registered. No address exceeds IFMAP_SIZE²-1.
- start while not in IDLE is ignored, including the DONE cycle. start held high in IDLE after DONE launches a new run.
- rst at any point forces IDLE and all counters to 0 next edge. In-flight mac_valid is dropped. No done is issued.

## Timing
- Reset values: busy, done, ifmap_rd_en, mac_valid, mac_clear, mac_last, ofmap_wr_en = 0. All addresses = 0.
- All outputs are registered.
- Start accepted at edge of cycle 0. First ifmap_rd_en in cycle 1, first mac_valid/mac_clear in cycle 2.
- Per pixel with ofmap_ready=1: FILTER_SIZE² LOAD + 1 WAIT + 1 WRITE = FILTER_SIZE²+2 cycles.
- Defaults: 11 cycles/pixel, 9 pixels. Final write in cycle 99, done in cycle 100.
- Each cycle of ofmap_ready=0 in WRITE adds exactly one cycle.

## Configuration
- CONV_SCHED_STALL_CNT_EN defined: adds output port stall_cnt (out, 16 bits).
  - Counts cycles spent in WRITE with ofmap_ready=0.
  - Cleared on start acceptance, saturates at 16'hFFFF, holds after done.
  - Reset value 0.
- Undefined: port and counter absent. Behaviour otherwise identical.

## Test plan
- Defaults, ofmap_ready tied 1, start pulse at cycle 0 → 81 rd_en cycles. First-window ifmap addresses 0,1,2,5,6,7,10,11,12. Writes to ofmap addrs 0..8 in order. done in cycle 100 only.
- Window (ox=2, oy=1) → ifmap addrs 7,8,9,12,13,14,17,18,19. filter addrs 0..8. mac_clear on first mac_valid only, mac_last on ninth.
- ofmap_ready=0 for 5 cycles at pixel 4 → wr_en and wr_addr=4 held stable. done in cycle 105. stall_cnt=5 when macro defined.
- start re-pulsed in cycles 3, 50 and 100 → ignored; no counter disturbance. start held high → second run starts the cycle after DONE.
- rst in cycle 40 → next cycle all outputs 0, state IDLE, no done. Subsequent start gives a clean 100-cycle run.
- IFMAP_SIZE=4, FILTER_SIZE=2, STRIDE=2 → 4 pixels, 6 cycles each. Window 3 ifmap addrs 10,11,14,15. done in cycle 25.
